fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Multi-cycle instruction-fetch controller. Replaces the free-running PC adder/register pair.
//  Owns the PC and issues one request at a time to instruction memory over a valid/ready
//  request channel plus a response channel. Presents each fetched instruction to decode over
//  a valid/ready handshake. Accepts redirects (jump/branch/trap), halt, and raises a sticky fetch fault.
// PARAMETERS
//  XLEN     64            address/PC width
//  ILEN     32            instruction width
//  RESET_PC 64'h8000_0000 PC loaded on reset
//  TIMEOUT  255           max cycles in WAIT before fault (8-bit counter; 0 = watchdog off)
// PORTS
//  clk            in  1    clock; all state updates on posedge
//  rst            in  1    synchronous, active-high reset
//  imem_req_valid out 1    fetch request valid
//  imem_req_ready in  1    memory accepts request
//  imem_req_addr  out XLEN fetch address (= PC)
//  imem_rsp_valid in  1    response valid (one per accepted request)
//  imem_rsp_data  in  ILEN fetched instruction
//  imem_rsp_err   in  1    bus error on this response
//  dec_valid      out 1    instruction available to decode
//  dec_ready      in  1    decode consumes instruction
//  dec_instr      out ILEN instruction to decode
//  dec_pc         out XLEN PC of dec_instr
//  redirect_valid in  1    next fetch comes from redirect_pc
//  redirect_pc    in  XLEN redirect target
//  halt           in  1    stop fetching after the current instruction (ebreak)
//  fetch_fault    out 1    sticky fault flag
//  fault_pc       out XLEN PC that faulted
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - state=IDLE, pc=RESET_PC, kill=0, wdog=0.
//   - Outputs: imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, fetch_fault=0, fault_pc=0.
//   - imem_req_addr=RESET_PC.
//  States: IDLE, REQ, WAIT, HOLD, FAULT.
//  IDLE:
//   - halt=0 -> REQ next cycle; otherwise stay.
//   - redirect in IDLE: pc<=redirect_pc; stay.
//  REQ:
//   - imem_req_valid=1, addr=pc; addr and valid held stable until ready.
//   - On ready: -> WAIT, wdog<=0.
//  WAIT:
//   - wdog increments each cycle.
//   - On rsp_valid with err=1 and kill=0: -> FAULT, fault_pc=pc.
//   - On rsp_valid with err=0 and kill=0: latch instr/pc, dec_valid=1 next cycle, -> HOLD.
//   - On rsp_valid with kill=1: discard response (errors included), kill<=0, -> REQ at the already-updated pc.
//   - wdog==TIMEOUT (TIMEOUT!=0) without rsp_valid: -> FAULT.
//  HOLD:
//   - dec_valid=1; dec_instr/dec_pc stable until handshake.
//   - On dec_valid&dec_ready: pc<=pc+4 (XLEN wrap), -> IDLE if halt else REQ.
//  Redirect (redirect_valid=1), any state except FAULT:
//   - redirect_pc[1:0]!=0 -> FAULT, fault_pc=redirect_pc.
//   - REQ with ready=0: the request stays valid (no retraction); pc<=redirect_pc; kill<=1.
//   - REQ with ready=1: pc<=redirect_pc; kill<=1; -> WAIT.
//   - WAIT: pc<=redirect_pc; kill<=1. If rsp_valid the same cycle, drop it and -> REQ.
//   - HOLD with dec_ready=1: the instruction counts as consumed; pc<=redirect_pc, not pc+4.
//   - HOLD with dec_ready=0: instruction dropped, dec_valid=0 next cycle, -> REQ.
//  Priority: rst > FAULT > misaligned redirect > redirect > halt > normal flow.
//  FAULT:
//   - All requests and dec_valid deasserted; fetch_fault=1.
//   - Sticky until rst; redirect and halt ignored.
//  imem_rsp_valid outside WAIT is ignored (stale response after reset).
//  Latency: pc->dec_valid = 1 (REQ) + memory latency + 1 cycle; back-to-back throughput = 1 per 3 cycles minimum.
// STRUCTURE
//  Package fetch_pkg: state enum fetch_state_t, RESET_PC default, ILEN, XLEN, PC_STEP=4.
//  Sub-module fetch_wdog: WAIT-state cycle counter with clear/enable/expired; rest is flat.
// TESTING
//  1. Reset, ready=1, 1-cycle rsp 32'h00000013, dec_ready=1 -> dec_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 in order.
//  2. dec_ready=0 for 5 cycles -> dec_valid, dec_instr, dec_pc stable; no new imem_req_valid.
//  3. Redirect 0x8000_0100 while in WAIT -> pending rsp discarded; next req addr 0x8000_0100; no stale dec_valid.
//  4. Redirect 0x8000_0102 -> fetch_fault=1, fault_pc=0x8000_0102; stays after redirect/halt toggles until rst.
//  5. imem_rsp_err=1 at pc 0x8000_0008 -> fault_pc=0x8000_0008. Separately, TIMEOUT=4 and no rsp -> fault in WAIT's 5th cycle.
//  6. halt=1 during HOLD -> after handshake, IDLE, no req. halt=0 -> req at pc+4. rst mid-WAIT -> req restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          DEF_XLEN     = 64;
    localparam int          DEF_ILEN     = 32;
    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
    localparam int          DEF_TIMEOUT  = 255;
    localparam int          WDOG_W       = 8;
    localparam int          PC_STEP      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } fetch_state_t;

    // Instructions are 4-byte aligned; the two low address bits must be zero.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// WAIT-state watchdog: counts cycles spent waiting for an instruction response.
module fetch_wdog
    import fetch_pkg::*;
#(
    parameter int          WIDTH = WDOG_W,
    parameter int unsigned LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LIMIT_W = LIMIT[WIDTH-1:0];

    logic [WIDTH-1:0] count;

    // Count while enabled; saturate at the limit so a lingering WAIT never wraps.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // A limit of zero disables the watchdog entirely.
    assign expired = (LIMIT_W != '0) && (count == LIMIT_W);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: owns the PC, issues one memory
// request at a time, hands instructions to decode, handles redirect/halt and
// raises a sticky fault on bus error, misaligned redirect or response timeout.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int             XLEN     = DEF_XLEN,
    parameter int             ILEN     = DEF_ILEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int             TIMEOUT  = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            kill;
    logic            kill_next;
    logic            load_dec;
    logic [XLEN-1:0] fault_pc_next;
    logic            redirect_bad;
    logic            wdog_expired;

    assign redirect_bad = redirect_valid && !is_aligned(redirect_pc[1:0]);

    fetch_wdog #(
        .WIDTH (WDOG_W),
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expired (wdog_expired)
    );

    // Next-state, next-PC and kill decisions in priority order:
    // FAULT > misaligned redirect > redirect > halt > normal flow.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a variable unassigned and infer a latch.
        state_next    = state;
        pc_next       = pc;
        kill_next     = kill;
        load_dec      = 1'b0;
        fault_pc_next = fault_pc;

        if (state == ST_FAULT) begin
            // Sticky until reset; redirect and halt are ignored.
            state_next = ST_FAULT;
        end else if (redirect_bad) begin
            state_next    = ST_FAULT;
            fault_pc_next = redirect_pc;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_next = redirect_pc;
                    end else if (!halt) begin
                        state_next = ST_REQ;
                    end
                end

                ST_REQ: begin
                    // The request is never retracted; a redirect marks its
                    // response for discard instead.
                    if (redirect_valid) begin
                        pc_next   = redirect_pc;
                        kill_next = 1'b1;
                    end
                    if (imem_req_ready) begin
                        state_next = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc_next = redirect_pc;
                    end
                    if (imem_rsp_valid) begin
                        if (kill || redirect_valid) begin
                            // Response belongs to an abandoned path; the
                            // outstanding request is now retired.
                            kill_next  = 1'b0;
                            state_next = ST_REQ;
                        end else if (imem_rsp_err) begin
                            state_next    = ST_FAULT;
                            fault_pc_next = pc;
                        end else begin
                            load_dec   = 1'b1;
                            state_next = ST_HOLD;
                        end
                    end else if (wdog_expired) begin
                        state_next    = ST_FAULT;
                        fault_pc_next = pc;
                    end else if (redirect_valid) begin
                        kill_next = 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (redirect_valid) begin
                        // Consumed or dropped, the next fetch is the target.
                        pc_next    = redirect_pc;
                        state_next = ST_REQ;
                    end else if (dec_ready) begin
                        pc_next    = pc + STEP;
                        state_next = halt ? ST_IDLE : ST_REQ;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, PC, kill flag and the registered request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            kill          <= 1'b0;
            imem_req_addr <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
            // Address is frozen while a request is offered so that a redirect
            // cannot change it before the memory accepts.
            if (state != ST_REQ) begin
                imem_req_addr <= pc_next;
            end
        end
    end

    // Decode-side holding registers and the fault address.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_instr <= '0;
            dec_pc    <= '0;
            fault_pc  <= '0;
        end else begin
            if (load_dec) begin
                dec_instr <= imem_rsp_data;
                dec_pc    <= pc;
            end
            fault_pc <= fault_pc_next;
        end
    end

    assign imem_req_valid = (state == ST_REQ);
    assign dec_valid      = (state == ST_HOLD);
    assign fetch_fault    = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a latency-programmable memory model,
// a decode scoreboard, and one task per scenario.
module tb_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        fetch_fault;
    logic [63:0] fault_pc;

    // Second instance with a short watchdog and a memory that never answers.
    logic        rst_t;
    logic        req_valid_t;
    logic        one_t;
    logic        zero_t;
    logic [63:0] req_addr_t;
    logic [31:0] zero_instr_t;
    logic [63:0] zero_pc_t;
    logic        dec_valid_t;
    logic [31:0] dec_instr_t;
    logic [63:0] dec_pc_t;
    logic        fetch_fault_t;
    logic [63:0] fault_pc_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic [63:0] pc; logic [31:0] instr; } dec_exp_t;
    typedef struct { logic [63:0] addr; int cnt; } pend_t;

    dec_exp_t    sb[$];
    pend_t       pend[$];
    int          hs_cyc[$];
    int          acc_cnt = 0;
    logic [63:0] acc_last = '0;

    int          mem_lat;
    bit          mem_fixed;
    bit          mem_mute;
    bit          mem_err_en;
    logic [63:0] mem_err_addr;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    fetch_sequencer #(.TIMEOUT(4)) dut_t4 (
        .clk            (clk),
        .rst            (rst_t),
        .imem_req_valid (req_valid_t),
        .imem_req_ready (one_t),
        .imem_req_addr  (req_addr_t),
        .imem_rsp_valid (zero_t),
        .imem_rsp_data  (zero_instr_t),
        .imem_rsp_err   (zero_t),
        .dec_valid      (dec_valid_t),
        .dec_ready      (one_t),
        .dec_instr      (dec_instr_t),
        .dec_pc         (dec_pc_t),
        .redirect_valid (zero_t),
        .redirect_pc    (zero_pc_t),
        .halt           (zero_t),
        .fetch_fault    (fetch_fault_t),
        .fault_pc       (fault_pc_t)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return mem_fixed ? 32'h0000_0013 : (a[31:0] ^ 32'hA5A5_0013);
    endfunction

    // Mid-cycle monitor: logs request acceptances and scores decode handshakes.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt++;
                acc_last = imem_req_addr;
                if (!mem_mute) pend.push_back('{imem_req_addr, mem_lat});
            end
            if (dec_valid && dec_ready) begin
                hs_cyc.push_back(cyc);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL dec_unexpected: got pc=%h instr=%h, required no decode output", dec_pc, dec_instr);
                end else begin
                    dec_exp_t e;
                    e = sb.pop_front();
                    if (dec_pc !== e.pc || dec_instr !== e.instr) begin
                        bad++;
                        $display("FAIL dec_data: got pc=%h instr=%h, required pc=%h instr=%h", dec_pc, dec_instr, e.pc, e.instr);
                    end
                end
            end
        end
    end

    // Memory response driver: one response per accepted request after mem_lat cycles.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_rsp_err   = 1'b0;
            if (rst) begin
                pend.delete();
            end else if (pend.size() > 0) begin
                pend[0].cnt = pend[0].cnt - 1;
                if (pend[0].cnt <= 0) begin
                    pend_t p;
                    p = pend.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(p.addr);
                    imem_rsp_err   = mem_err_en && (p.addr == mem_err_addr);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [63:0] pc);
        sb.push_back('{pc, mem_data(pc)});
    endtask

    // Asserts reset with quiet inputs; caller releases it.
    task automatic hold_reset(input bit halt_v);
        rst            = 1'b1;
        halt           = halt_v;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        mem_fixed      = 1'b0;
        mem_mute       = 1'b0;
        mem_err_en     = 1'b0;
        mem_err_addr   = '0;
        sb.delete();
        pend.delete();
        hs_cyc.delete();
        step(2);
    endtask

    task automatic wait_sb(input int limit, output bit drained);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            step(1);
            n++;
        end
        drained = (sb.size() == 0);
        sb.delete();
    endtask

    task automatic wait_accept(input int limit, output bit seen, output logic [63:0] addr);
        int base = acc_cnt;
        int n = 0;
        while (acc_cnt == base && n < limit) begin
            step(1);
            n++;
        end
        seen = (acc_cnt != base);
        addr = acc_last;
    endtask

    task automatic test_reset();
        hold_reset(1'b0);
        @(negedge clk);
        total += 7;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
        if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL rst_req_addr: got %h, required %h", imem_req_addr, RST_PC); end
        if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid: got %b, required 0", dec_valid); end
        if (dec_instr !== 32'h0) begin bad++; $display("FAIL rst_dec_instr: got %h, required 0", dec_instr); end
        if (dec_pc !== 64'h0) begin bad++; $display("FAIL rst_dec_pc: got %h, required 0", dec_pc); end
        if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b, required 0", fetch_fault); end
        if (fault_pc !== 64'h0) begin bad++; $display("FAIL rst_fault_pc: got %h, required 0", fault_pc); end
        step(1);
    endtask

    // Three sequential fetches at one instruction per three cycles.
    task automatic test_sequential();
        bit drained;
        hold_reset(1'b0);
        mem_fixed = 1'b1;
        dec_ready = 1'b1;
        push_exp(RST_PC);
        push_exp(RST_PC + 64'd4);
        push_exp(RST_PC + 64'd8);
        rst = 1'b0;
        wait_sb(60, drained);
        dec_ready = 1'b0;
        total++;
        if (!drained) begin bad++; $display("FAIL seq_drain: got pending entries, required 3 decodes within 60 cycles"); end
        total++;
        if (hs_cyc.size() < 3 || hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 3) begin
            bad++;
            $display("FAIL seq_throughput: got %0d handshakes with irregular spacing, required 3 spaced 3 cycles apart", hs_cyc.size());
        end
    endtask

    // Decode stall: held instruction stays stable and no new request is issued.
    task automatic test_stall();
        bit drained;
        int n = 0;
        while (!dec_valid && n < 10) begin
            step(1);
            n++;
        end
        total++;
        if (!dec_valid) begin bad++; $display("FAIL stall_arrive: got dec_valid=0, required 1 within 10 cycles"); end
        repeat (5) begin
            @(negedge clk);
            total += 4;
            if (dec_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b, required 1", dec_valid); end
            if (dec_instr !== 32'h13) begin bad++; $display("FAIL stall_instr: got %h, required 00000013", dec_instr); end
            if (dec_pc !== RST_PC + 64'd12) begin bad++; $display("FAIL stall_pc: got %h, required %h", dec_pc, RST_PC + 64'd12); end
            if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_no_req: got %b, required 0", imem_req_valid); end
        end
        step(1);
        push_exp(RST_PC + 64'd12);
        dec_ready = 1'b1;
        wait_sb(5, drained);
        dec_ready = 1'b0;
        total++;
        if (!drained) begin bad++; $display("FAIL stall_release: got no handshake, required one"); end
    endtask

    // Redirect while a response is outstanding: the response must be discarded.
    task automatic test_redirect_wait();
        bit          seen;
        bit          drained;
        logic [63:0] addr;
        hold_reset(1'b0);
        mem_lat   = 3;
        dec_ready = 1'b1;
        rst       = 1'b0;
        wait_accept(10, seen, addr);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step(1);
        redirect_valid = 1'b0;
        push_exp(64'h8000_0100);
        wait_accept(15, seen, addr);
        total++;
        if (!seen || addr !== 64'h8000_0100) begin
            bad++;
            $display("FAIL redir_addr: got seen=%0d addr=%h, required 80000100", seen, addr);
        end
        wait_sb(15, drained);
        dec_ready = 1'b0;
        total++;
        if (!drained) begin bad++; $display("FAIL redir_decode: got no decode of target, required one"); end
    endtask

    // Misaligned redirect faults and the fault survives redirect/halt activity.
    task automatic test_misaligned();
        hold_reset(1'b0);
        rst = 1'b0;
        step(4);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        total += 4;
        if (fetch_fault !== 1'b1) begin bad++; $display("FAIL mis_fault: got %b, required 1", fetch_fault); end
        if (fault_pc !== 64'h8000_0102) begin bad++; $display("FAIL mis_fault_pc: got %h, required 80000102", fault_pc); end
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req: got %b, required 0", imem_req_valid); end
        if (dec_valid !== 1'b0) begin bad++; $display("FAIL mis_dec: got %b, required 0", dec_valid); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            redirect_valid = i[0];
            redirect_pc    = 64'h8000_0200;
            halt           = ~i[0];
            @(negedge clk);
            total += 2;
            if (fetch_fault !== 1'b1) begin bad++; $display("FAIL mis_sticky: got %b, required 1", fetch_fault); end
            if (fault_pc !== 64'h8000_0102) begin bad++; $display("FAIL mis_sticky_pc: got %h, required 80000102", fault_pc); end
        end
        step(1);
        redirect_valid = 1'b0;
        halt           = 1'b0;
        rst            = 1'b1;
        step(1);
        @(negedge clk);
        total += 2;
        if (fetch_fault !== 1'b0) begin bad++; $display("FAIL mis_clear: got %b, required 0", fetch_fault); end
        if (fault_pc !== 64'h0) begin bad++; $display("FAIL mis_clear_pc: got %h, required 0", fault_pc); end
        step(1);
        rst = 1'b0;
    endtask

    // Bus error on the third fetch.
    task automatic test_bus_error();
        int n = 0;
        hold_reset(1'b0);
        mem_err_en   = 1'b1;
        mem_err_addr = RST_PC + 64'd8;
        dec_ready    = 1'b1;
        push_exp(RST_PC);
        push_exp(RST_PC + 64'd4);
        rst = 1'b0;
        while (!fetch_fault && n < 40) begin
            step(1);
            n++;
        end
        dec_ready = 1'b0;
        total += 3;
        if (fetch_fault !== 1'b1) begin bad++; $display("FAIL err_fault: got %b, required 1", fetch_fault); end
        if (fault_pc !== RST_PC + 64'd8) begin bad++; $display("FAIL err_fault_pc: got %h, required %h", fault_pc, RST_PC + 64'd8); end
        if (sb.size() != 0) begin bad++; $display("FAIL err_decodes: got %0d missing decodes, required 0", sb.size()); end
        sb.delete();
    endtask

    // Watchdog of 4: fault is taken in the fifth WAIT cycle.
    task automatic test_timeout();
        int n = 0;
        int waits = 0;
        rst_t = 1'b1;
        step(2);
        rst_t = 1'b0;
        while (!req_valid_t && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (fetch_fault_t) break;
            waits++;
            n++;
        end
        total += 2;
        if (waits != 5) begin bad++; $display("FAIL tmo_cycles: got %0d clean WAIT cycles, required 5", waits); end
        if (fault_pc_t !== RST_PC) begin bad++; $display("FAIL tmo_fault_pc: got %h, required %h", fault_pc_t, RST_PC); end
        step(1);
    endtask

    // Halt after a handshake, resume at pc+4; redirect in IDLE; reset mid-WAIT.
    task automatic test_halt_restart();
        bit          seen;
        bit          drained;
        logic [63:0] addr;
        int          n = 0;
        int          reqs = 0;
        hold_reset(1'b0);
        rst = 1'b0;
        while (!dec_valid && n < 10) begin
            step(1);
            n++;
        end
        halt = 1'b1;
        push_exp(RST_PC);
        dec_ready = 1'b1;
        step(1);
        dec_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req_valid) reqs++;
        end
        total += 2;
        if (reqs != 0) begin bad++; $display("FAIL halt_idle: got %0d request cycles, required 0", reqs); end
        if (sb.size() != 0) begin bad++; $display("FAIL halt_consume: got %0d pending, required 0", sb.size()); end
        step(1);
        halt = 1'b0;
        wait_accept(10, seen, addr);
        total++;
        if (!seen || addr !== RST_PC + 64'd4) begin
            bad++;
            $display("FAIL halt_resume: got seen=%0d addr=%h, required %h", seen, addr, RST_PC + 64'd4);
        end

        hold_reset(1'b1);
        rst = 1'b0;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        step(1);
        redirect_valid = 1'b0;
        halt           = 1'b0;
        mem_mute       = 1'b1;
        wait_accept(10, seen, addr);
        total++;
        if (!seen || addr !== 64'h8000_0200) begin
            bad++;
            $display("FAIL idle_redirect: got seen=%0d addr=%h, required 80000200", seen, addr);
        end
        step(2);
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        mem_mute  = 1'b0;
        dec_ready = 1'b1;
        push_exp(RST_PC);
        wait_accept(10, seen, addr);
        total++;
        if (!seen || addr !== RST_PC) begin
            bad++;
            $display("FAIL wait_reset: got seen=%0d addr=%h, required %h", seen, addr, RST_PC);
        end
        wait_sb(10, drained);
        dec_ready = 1'b0;
        total++;
        if (!drained) begin bad++; $display("FAIL wait_reset_decode: got no decode, required one at reset pc"); end
    endtask

    initial begin
        rst_t        = 1'b1;
        one_t        = 1'b1;
        zero_t       = 1'b0;
        zero_instr_t = '0;
        zero_pc_t    = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_halt_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1);
    end

endmodule
